// File: rtl/mix_columns_pipe.sv
// Pipelined AES MixColumns / InvMixColumns over NUM_COLS columns with valid/ready flow control.
// Define MIX_COLUMNS_PIPE_BYPASS_EN to add bypass_i, which passes a beat through untransformed.
module mix_columns_pipe #(
    parameter int NUM_COLS = 4,
    parameter int LATENCY  = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      valid_i,
    output logic                      ready_o,
    input  logic                      inv_i,
`ifdef MIX_COLUMNS_PIPE_BYPASS_EN
    input  logic                      bypass_i,
`endif
    input  logic [32*NUM_COLS-1:0]    state_i,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic [32*NUM_COLS-1:0]    state_o
);
    localparam int W = 32 * NUM_COLS;

    if (NUM_COLS < 1 || NUM_COLS > 8) begin : g_bad_num_cols
        $error("mix_columns_pipe: NUM_COLS must be in 1..8");
    end
    if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
        $error("mix_columns_pipe: LATENCY must be in 1..4");
    end

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Every product is assembled from x2/x4/x8 xtime chains so no general multiplier is needed.
    function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
        logic [7:0] s   [4];
        logic [7:0] x2  [4];
        logic [7:0] x4  [4];
        logic [7:0] x8  [4];
        logic [31:0] res;
        res = '0;
        for (int i = 0; i < 4; i++) begin
            s[i]  = col[31-8*i -: 8];
            x2[i] = xtime(s[i]);
            x4[i] = xtime(x2[i]);
            x8[i] = xtime(x4[i]);
        end
        for (int r = 0; r < 4; r++) begin
            if (inv) begin
                res[31-8*r -: 8] = (x8[r] ^ x4[r] ^ x2[r])
                                 ^ (x8[(r+1)%4] ^ x2[(r+1)%4] ^ s[(r+1)%4])
                                 ^ (x8[(r+2)%4] ^ x4[(r+2)%4] ^ s[(r+2)%4])
                                 ^ (x8[(r+3)%4] ^ s[(r+3)%4]);
            end else begin
                res[31-8*r -: 8] = x2[r]
                                 ^ (x2[(r+1)%4] ^ s[(r+1)%4])
                                 ^ s[(r+2)%4]
                                 ^ s[(r+3)%4];
            end
        end
        return res;
    endfunction

    logic              use_mix;
    logic [W-1:0]      mixed;
    logic [LATENCY-1:0] en;
    logic [LATENCY-1:0] vq;
    logic [W-1:0]      data_q [LATENCY];
    logic              en_acc;

`ifdef MIX_COLUMNS_PIPE_BYPASS_EN
    assign use_mix = !bypass_i;
`else
    assign use_mix = 1'b1;
`endif

    always_comb begin
        mixed = '0;
        for (int c = 0; c < NUM_COLS; c++) begin
            mixed[32*c +: 32] = use_mix ? mix_col(state_i[32*c +: 32], inv_i) : state_i[32*c +: 32];
        end
    end

    // A stage may load if it or any stage after it is empty, or the sink is taking the last beat.
    always_comb begin
        en     = '0;
        en_acc = ready_i;
        for (int k = LATENCY - 1; k >= 0; k--) begin
            en_acc = en_acc || !vq[k];
            en[k]  = en_acc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vq <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            if (en[0]) begin
                vq[0]     <= valid_i;
                data_q[0] <= mixed;
            end
            for (int k = 1; k < LATENCY; k++) begin
                if (en[k]) begin
                    vq[k]     <= vq[k-1];
                    data_q[k] <= data_q[k-1];
                end
            end
        end
    end

    assign ready_o = en[0];
    assign valid_o = vq[LATENCY-1];
    assign state_o = data_q[LATENCY-1];

endmodule
